// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarding operand select, load-use bubble insertion,
// branch-flush bubbles and saturating stall/flush event counters.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic              fwdEX_r1,
   input  logic              fwdWB_r1,
   input  logic              fwdEX_r2,
   input  logic              fwdWB_r2,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic [XLEN-1:0]   wb_fwd_data,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rd,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            hz;

   always_comb begin
      op1 = fwdEX_r1 ? ex_fwd_data : (fwdWB_r1 ? wb_fwd_data : rf_rdata1);
      op2 = fwdEX_r2 ? ex_fwd_data : (fwdWB_r2 ? wb_fwd_data : rf_rdata2);
   end

   // Loads to x0 never stall; EX control bits are zero for bubbles, so no false match.
   always_comb begin
      hz = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   end

   assign stall = hz & ~flush & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_op1      <= '0;
         ex_op2      <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_ctrl     <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         if (id_valid && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (hz) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_op1      <= op1;
         ex_op2      <= op2;
         ex_imm      <= id_imm;
         ex_rd       <= id_rd;
         ex_regwrite <= id_valid & id_regwrite;
         ex_memread  <= id_valid & id_memread;
         ex_memwrite <= id_valid & id_memwrite;
         ex_ctrl     <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forwarding vector table, hand-written hazard/flush/reset
// sequences, and randomized traffic against a behavioural pipeline-slot model.
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              id_valid = 1'b0;
   logic [XLEN-1:0]   id_pc = '0;
   logic [4:0]        id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic              id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0;
   logic [CTRL_W-1:0] id_ctrl = '0;
   logic [XLEN-1:0]   id_imm = '0;
   logic [XLEN-1:0]   rf_rdata1 = '0, rf_rdata2 = '0;
   logic              fwdEX_r1 = 1'b0, fwdWB_r1 = 1'b0, fwdEX_r2 = 1'b0, fwdWB_r2 = 1'b0;
   logic [XLEN-1:0]   ex_fwd_data = '0, wb_fwd_data = '0;
   logic              flush = 1'b0;
   logic              stall;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_op1, ex_op2, ex_imm;
   logic [4:0]        ex_rd;
   logic              ex_regwrite, ex_memread, ex_memwrite;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_ctrl(id_ctrl), .id_imm(id_imm), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwdEX_r1(fwdEX_r1), .fwdWB_r1(fwdWB_r1), .fwdEX_r2(fwdEX_r2), .fwdWB_r2(fwdWB_r2),
      .ex_fwd_data(ex_fwd_data), .wb_fwd_data(wb_fwd_data), .flush(flush),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
      .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the instruction slot sitting in EX.
   bit           m_valid, m_rw, m_mr, m_mw, m_ctrl_known;
   int unsigned  m_pc, m_op1, m_op2, m_imm, m_rd, m_ctrl;
   int           m_scnt, m_fcnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_hz();
      return id_valid && m_valid && m_mr && (m_rd != 0) &&
             (m_rd == int'(id_rs1) || m_rd == int'(id_rs2));
   endfunction

   function automatic int unsigned pick(bit f_ex, bit f_wb, int unsigned rf);
      if (f_ex) return ex_fwd_data;
      if (f_wb) return wb_fwd_data;
      return rf;
   endfunction

   task automatic model_reset();
      {m_valid, m_rw, m_mr, m_mw} = '0;
      m_ctrl_known = 1'b1;
      m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
      m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic model_edge();
      if (flush) begin
         {m_valid, m_rw, m_mr, m_mw} = '0;
         if (id_valid && m_fcnt < CNT_MAX) m_fcnt++;
      end else if (model_hz()) begin
         {m_valid, m_rw, m_mr, m_mw} = '0;
         if (m_scnt < CNT_MAX) m_scnt++;
      end else begin
         m_valid = id_valid;
         m_pc  = id_pc;
         m_imm = id_imm;
         m_rd  = id_rd;
         m_op1 = pick(fwdEX_r1, fwdWB_r1, rf_rdata1);
         m_op2 = pick(fwdEX_r2, fwdWB_r2, rf_rdata2);
         m_rw  = id_valid && id_regwrite;
         m_mr  = id_valid && id_memread;
         m_mw  = id_valid && id_memwrite;
         m_ctrl = id_ctrl;
         m_ctrl_known = id_valid;
      end
   endtask

   // Advance one clock: update the model from the presented inputs, then sample after the edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".ex_valid"},    ex_valid,    m_valid);
      chk({tag, ".ex_regwrite"}, ex_regwrite, m_rw);
      chk({tag, ".ex_memread"},  ex_memread,  m_mr);
      chk({tag, ".ex_memwrite"}, ex_memwrite, m_mw);
      chk({tag, ".ex_rd"},       ex_rd,       m_rd);
      chk({tag, ".ex_pc"},       ex_pc,       m_pc);
      chk({tag, ".ex_op1"},      ex_op1,      m_op1);
      chk({tag, ".ex_op2"},      ex_op2,      m_op2);
      chk({tag, ".ex_imm"},      ex_imm,      m_imm);
      if (m_ctrl_known) chk({tag, ".ex_ctrl"}, ex_ctrl, m_ctrl);
      chk({tag, ".stall_cnt"},   stall_cnt,   m_scnt);
      chk({tag, ".flush_cnt"},   flush_cnt,   m_fcnt);
   endtask

   task automatic set_id(input bit v, input int unsigned pc, input int unsigned rs1,
                         input int unsigned rs2, input int unsigned rd,
                         input bit rw, input bit mr, input bit mw);
      id_valid = v; id_pc = pc; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
      id_regwrite = rw; id_memread = mr; id_memwrite = mw;
   endtask

   task automatic clear_fwd();
      {fwdEX_r1, fwdWB_r1, fwdEX_r2, fwdWB_r2} = '0;
   endtask

   task automatic do_reset();
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      clear_fwd();
      rst = 1'b1;
      #3;
      model_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      bit          f_ex1, f_wb1, f_ex2, f_wb2;
      int unsigned exp1, exp2;
   } fwd_vec_t;

   fwd_vec_t vecs[7];

   initial begin
      vecs[0] = '{"op1_ex_over_wb", 1, 1, 0, 0, 32'h33, 32'h55};
      vecs[1] = '{"op1_wb",         0, 1, 0, 0, 32'h22, 32'h55};
      vecs[2] = '{"op1_rf",         0, 0, 0, 0, 32'h11, 32'h55};
      vecs[3] = '{"op2_ex_over_wb", 0, 0, 1, 1, 32'h11, 32'h33};
      vecs[4] = '{"op2_wb",         0, 0, 0, 1, 32'h11, 32'h22};
      vecs[5] = '{"op2_ex",         0, 0, 1, 0, 32'h11, 32'h33};
      vecs[6] = '{"both_mixed",     1, 0, 0, 1, 32'h33, 32'h22};

      // Reset state
      model_reset();
      #2;
      chk("reset.stall", stall, 1'b0);
      do_reset();
      compare_all("reset");
      chk("reset.stall_after", stall, 1'b0);

      // Forwarding priority table
      rf_rdata1 = 32'h11; rf_rdata2 = 32'h55; wb_fwd_data = 32'h22; ex_fwd_data = 32'h33;
      foreach (vecs[i]) begin
         set_id(1, 32'h100 + 4 * i, 1, 2, 3, 1, 0, 0);
         {fwdEX_r1, fwdWB_r1, fwdEX_r2, fwdWB_r2} =
            {vecs[i].f_ex1, vecs[i].f_wb1, vecs[i].f_ex2, vecs[i].f_wb2};
         tick();
         chk({vecs[i].name, ".op1"}, ex_op1, vecs[i].exp1);
         chk({vecs[i].name, ".op2"}, ex_op2, vecs[i].exp2);
      end
      clear_fwd();

      // Load-use: lw x5 in EX, dependent add in ID
      do_reset();
      set_id(1, 32'h200, 1, 0, 5, 1, 1, 0);
      tick();
      set_id(1, 32'h204, 1, 5, 6, 1, 0, 0);
      #1;
      chk("lu.stall", stall, 1'b1);
      tick();
      chk("lu.bubble_valid", ex_valid, 1'b0);
      chk("lu.bubble_regwrite", ex_regwrite, 1'b0);
      chk("lu.stall_cnt", stall_cnt, 1);
      chk("lu.stall_released", stall, 1'b0);
      wb_fwd_data = 32'hABCD; fwdWB_r2 = 1'b1;
      tick();
      chk("lu.add_valid", ex_valid, 1'b1);
      chk("lu.add_op2", ex_op2, 32'hABCD);
      chk("lu.add_rd", ex_rd, 6);
      chk("lu.add_pc", ex_pc, 32'h204);
      clear_fwd();

      // Load to x0 never stalls
      set_id(1, 32'h300, 0, 0, 0, 1, 1, 0);
      tick();
      set_id(1, 32'h304, 0, 7, 8, 1, 0, 0);
      #1;
      chk("x0.stall", stall, 1'b0);
      tick();
      chk("x0.advance_valid", ex_valid, 1'b1);
      chk("x0.advance_pc", ex_pc, 32'h304);

      // Flush beats stall
      do_reset();
      set_id(1, 32'h400, 0, 0, 5, 1, 1, 0);
      tick();
      set_id(1, 32'h404, 5, 0, 9, 1, 0, 1);
      flush = 1'b1;
      #1;
      chk("fl.stall", stall, 1'b0);
      tick();
      flush = 1'b0;
      chk("fl.valid", ex_valid, 1'b0);
      chk("fl.memwrite", ex_memwrite, 1'b0);
      chk("fl.flush_cnt", flush_cnt, 1);
      chk("fl.stall_cnt", stall_cnt, 0);
      chk("fl.pc_held", ex_pc, 32'h400);

      // Asynchronous reset mid-cycle while a hazard is pending
      set_id(1, 32'h500, 0, 0, 5, 1, 1, 0);
      tick();
      set_id(1, 32'h504, 5, 5, 1, 1, 0, 0);
      #1;
      chk("ar.stall_pre", stall, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all("ar");
      chk("ar.stall", stall, 1'b0);
      #2;
      rst = 1'b0;
      set_id(1, 32'h600, 1, 2, 4, 1, 0, 0);
      tick();
      chk("ar.first_valid", ex_valid, 1'b1);
      chk("ar.first_pc", ex_pc, 32'h600);

      // Counter saturation: 20 load-use stalls
      do_reset();
      for (int k = 0; k < 20; k++) begin
         set_id(1, 32'h700, 0, 0, 5, 1, 1, 0);
         tick();
         set_id(1, 32'h704, 5, 0, 2, 1, 0, 0);
         tick();
      end
      chk("sat.stall_cnt", stall_cnt, CNT_MAX);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_id($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         id_ctrl = 8'($urandom);
         id_imm = $urandom;
         rf_rdata1 = $urandom; rf_rdata2 = $urandom;
         ex_fwd_data = $urandom; wb_fwd_data = $urandom;
         {fwdEX_r1, fwdWB_r1, fwdEX_r2, fwdWB_r2} = 4'($urandom);
         flush = ($urandom_range(0, 9) == 0);
         #1;
         chk("rnd.stall", stall, model_hz() && !flush);
         tick();
         compare_all("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Selects ID-stage source operands from the register file or the EX/WB forwarding paths, using the forwarding unit's select bits. Registers the operands and control into EX.
- Detects load-use hazards and inserts one-cycle bubbles. Honours branch flushes.
- Its registered ex_rd/ex_regwrite feed the forwarding unit's EX_rd/EX_regwrite inputs.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, width of opaque ALU/branch control bundle passed through.
- CNT_W, 16, width of saturating stall/flush event counters.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2  in  5  source register indices
- id_rd  in  5  destination index
- id_regwrite, id_memread, id_memwrite  in  1  ID control
- id_ctrl  in  CTRL_W  pass-through control
- id_imm  in  XLEN  decoded immediate
- rf_rdata1, rf_rdata2  in  XLEN  register file read data
- fwdEX_r1, fwdWB_r1, fwdEX_r2, fwdWB_r2  in  1  forwarding selects
- ex_fwd_data  in  XLEN  result of instruction currently in EX
- wb_fwd_data  in  XLEN  result of instruction in MEM/WB
- flush  in  1  branch/jump resolved taken; kill ID instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds real instruction
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN  registered EX operands
- ex_rd  out  5
- ex_regwrite, ex_memread, ex_memwrite  out  1
- ex_ctrl  out  CTRL_W
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset, asynchronous, active-high: every registered output goes to 0, including both counters. stall is 0 while rst is high.
- Operand select is combinational. op1 = ex_fwd_data if fwdEX_r1, else wb_fwd_data if fwdWB_r1, else rf_rdata1. op2 follows the same rule with the r2 selects. EX has priority if both selects are high.
- Load-use hazard, hz, is high when all of the following hold:
  - id_valid & ex_valid & ex_memread
  - ex_rd != 0
  - ex_rd == id_rs1 or ex_rd == id_rs2
- stall = hz & ~flush & ~rst.
- Each rising edge, in priority order:
  1. flush: the bubble is loaded. ex_valid, ex_regwrite, ex_memread and ex_memwrite are 0; the other fields are don't-care and are held. flush_cnt increments if id_valid.
  2. hz: the bubble is loaded. stall_cnt increments.
  3. Otherwise: all id_* fields and the selected op1/op2 are loaded, and ex_valid = id_valid. If id_valid = 0, the control bits load as 0.
- Latency is 1 cycle, ID to EX. A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM/WB, the bubble is in EX, hz is 0, and the operand arrives via fwdWB.
- Control bits of a bubble or invalid slot are always 0, so the forwarding unit never matches on them.
- A load with ex_rd = 0 never stalls.
- A load that is a source of itself (rd == rs1 of the next instruction), or a store whose data depends on the load, still stalls 1 cycle. No MEM→MEM bypass exists.
- Counters saturate at all-ones and do not wrap.
- If rst asserts mid-stall, outputs clear immediately, asynchronously. After release, the first edge loads normally.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle with ex_valid=1 -> all outputs 0 before the next edge; stall=0.
- Forward priority: rf_rdata1=0x11, wb_fwd_data=0x22, ex_fwd_data=0x33. fwdEX_r1=fwdWB_r1=1 -> ex_op1=0x33 after the edge. fwdWB_r1 alone -> 0x22. Neither -> 0x11. Repeat for op2.
- Load-use: EX holds lw x5 (ex_memread=1, ex_rd=5); ID has add using rs2=5 -> stall=1 for one cycle, ex_valid=0 next, stall_cnt=1. Next cycle stall=0 and the add is registered with the fwdWB operand.
- Load to x0: lw with ex_rd=0 and dependent id_rs1=0 -> stall=0; the instruction advances.
- Flush beats stall: hz condition true and flush=1 -> stall=0, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- Counter saturation: with CNT_W=4, force 20 load-use stalls -> stall_cnt holds 15.
